// File: rtl/logic_ops_pkg.sv
// Shared types and constants for the 8-bit structural logic-ops slice.
package logic_ops_pkg;

  localparam int BYTE_W = 8;

  typedef logic [BYTE_W-1:0] byte_t;

  localparam byte_t BYTE_ZERO = 8'h00;
  localparam byte_t BYTE_ONES = 8'hFF;

endpackage : logic_ops_pkg

// File: rtl/and_8_bits_struct_if.sv
// Operand/result bundle for the 8-bit structural AND block.
interface and_8_bits_struct_if;
  import logic_ops_pkg::*;

  byte_t a;
  byte_t b;
  logic  in_valid;
  byte_t s;
  logic  s_zero;
  logic  s_ones;
  byte_t s_q;
  logic  s_q_valid;

  modport master (
    output a, b, in_valid,
    input  s, s_zero, s_ones, s_q, s_q_valid
  );

  modport slave (
    input  a, b, in_valid,
    output s, s_zero, s_ones, s_q, s_q_valid
  );

endinterface : and_8_bits_struct_if

// File: rtl/and_1_bit_cell.sv
// Single-bit AND cell built on the gate primitive; X/Z follow gate semantics.
module and_1_bit_cell (
  input  logic a,
  input  logic b,
  output logic y
);

  and u_and (y, a, b);

endmodule : and_1_bit_cell

// File: rtl/and_8_bits_struct.sv
// Structural 8-bit AND: combinational result and flags, plus a registered
// copy with a valid flag for clocked consumers.
module and_8_bits_struct
  import logic_ops_pkg::*;
#(
  parameter int WIDTH = BYTE_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  and_8_bits_struct_if.slave   bus
);

  if (WIDTH != BYTE_W) begin : g_width_check
    $error("and_8_bits_struct: WIDTH must be 8");
  end

  byte_t s_comb;
  byte_t s_q_r;
  logic  s_q_valid_r;

  for (genvar i = 0; i < BYTE_W; i++) begin : g_bit
    and_1_bit_cell u_cell (
      .a (bus.a[i]),
      .b (bus.b[i]),
      .y (s_comb[i])
    );
  end

  // Flags are pure reductions of the gate outputs, so they ignore reset.
  assign bus.s      = s_comb;
  assign bus.s_zero = ~|s_comb;
  assign bus.s_ones = &s_comb;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the async reset branch clears without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q_r       <= BYTE_ZERO;
      s_q_valid_r <= 1'b0;
    end else begin
      s_q_valid_r <= bus.in_valid;
      if (bus.in_valid) begin
        s_q_r <= s_comb;
      end
    end
  end

  assign bus.s_q       = s_q_r;
  assign bus.s_q_valid = s_q_valid_r;

endmodule : and_8_bits_struct

// File: tb/tb_and_8_bits_struct.sv
// Directed bench for and_8_bits_struct: vector table for the combinational
// path, hand-written sequences for the registered path and async reset.
module tb_and_8_bits_struct;
  import logic_ops_pkg::*;

  typedef struct {
    byte_t a;
    byte_t b;
    byte_t s;
    logic  z;
    logic  o;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  and_8_bits_struct_if bus ();

  and_8_bits_struct #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  vec_t vecs[8];

  initial begin
    byte_t wa;

    vecs[0] = '{8'hFF, 8'h00, 8'h00, 1'b1, 1'b0};
    vecs[1] = '{8'hFF, 8'hA9, 8'hA9, 1'b0, 1'b0};
    vecs[2] = '{8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b1};
    vecs[3] = '{8'h00, 8'hFF, 8'h00, 1'b1, 1'b0};
    vecs[4] = '{8'h3C, 8'h0F, 8'h0C, 1'b0, 1'b0};
    vecs[5] = '{8'h55, 8'hAA, 8'h00, 1'b1, 1'b0};
    vecs[6] = '{8'hF7, 8'h7F, 8'h77, 1'b0, 1'b0};
    vecs[7] = '{8'h80, 8'hC1, 8'h80, 1'b0, 1'b0};

    bus.a        = 8'h00;
    bus.b        = 8'h00;
    bus.in_valid = 1'b0;

    // Reset state, applied between edges.
    #1 rst_n = 1'b0;
    #1;
    check("rst_s_q", bus.s_q, 8'h00);
    check("rst_s_q_valid", 8'(bus.s_q_valid), 8'h00);

    // Combinational path while reset is held: s must not depend on rst_n.
    for (int i = 0; i < 8; i++) begin
      bus.a = vecs[i].a;
      bus.b = vecs[i].b;
      #10;
      check($sformatf("vec%0d_s", i), bus.s, vecs[i].s);
      check($sformatf("vec%0d_zero", i), 8'(bus.s_zero), 8'(vecs[i].z));
      check($sformatf("vec%0d_ones", i), 8'(bus.s_ones), 8'(vecs[i].o));
    end

    // Walking one against all-ones, then against its complement.
    for (int i = 0; i < 8; i++) begin
      wa = 8'h01 << i;
      bus.a = wa;
      bus.b = 8'hFF;
      #1;
      check($sformatf("walk%0d_pass", i), bus.s, wa);
      bus.b = ~wa;
      #1;
      check($sformatf("walk%0d_block", i), bus.s, 8'h00);
    end

    // Edges during reset must not capture.
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    check("rst_hold_s_q", bus.s_q, 8'h00);
    check("rst_hold_valid", 8'(bus.s_q_valid), 8'h00);

    // Release reset and capture 3C & 0F.
    @(negedge clk);
    rst_n        = 1'b1;
    bus.a        = 8'h3C;
    bus.b        = 8'h0F;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    check("cap1_s_q", bus.s_q, 8'h0C);
    check("cap1_valid", 8'(bus.s_q_valid), 8'h01);

    // Drop in_valid with new operands: s_q must hold, valid must fall.
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a        = 8'hFF;
    bus.b        = 8'hFF;
    @(posedge clk); #1;
    check("hold_s_q", bus.s_q, 8'h0C);
    check("hold_valid", 8'(bus.s_q_valid), 8'h00);

    // Async reset mid-cycle while in_valid is pending.
    @(negedge clk);
    bus.in_valid = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("async_s_q", bus.s_q, 8'h00);
    check("async_valid", 8'(bus.s_q_valid), 8'h00);
    check("async_comb_s", bus.s, 8'hFF);
    check("async_comb_ones", 8'(bus.s_ones), 8'h01);

    // First capture after release, then back-to-back captures.
    @(negedge clk);
    rst_n = 1'b1;
    bus.a = 8'h5A;
    bus.b = 8'hF0;
    @(posedge clk); #1;
    check("rel_s_q", bus.s_q, 8'h50);
    check("rel_valid", 8'(bus.s_q_valid), 8'h01);
    @(negedge clk);
    bus.a = 8'hC3;
    bus.b = 8'h3C;
    @(posedge clk); #1;
    check("b2b_s_q", bus.s_q, 8'h00);
    check("b2b_valid", 8'(bus.s_q_valid), 8'h01);
    check("b2b_zero", 8'(bus.s_zero), 8'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_and_8_bits_struct

// File: doc/and_8_bits_struct.md
Name: and_8_bits_struct

Overview:
- Structural 8-bit bitwise AND: S = A & B, built from per-bit gate cells.
- Combinational result for the datapath, plus a registered copy with a valid flag for clocked consumers.
- Sits in the ALU logic-ops slice alongside the other 8-bit structural gate blocks.

Parameters:
- WIDTH, 8, operand/result width; only 8 is supported, and elaboration fails via an assertion for any other value.

Ports:
- clk  input  1  rising-edge clock for the registered path
- rst_n  input  1  reset, asynchronous assert, active-low
- a  input  8  operand A
- b  input  8  operand B
- in_valid  input  1  qualifies a/b for capture into the registered path
- s  output  8  combinational result a & b
- s_zero  output  1  combinational; 1 when s == 8'h00
- s_ones  output  1  combinational; 1 when s == 8'hFF
- s_q  output  8  registered result
- s_q_valid  output  1  registered valid for s_q

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- s[i] = a[i] AND b[i] for i = 0..7.
  - Pure combinational, zero cycles of latency.
  - Valid within the same delta/settle time as an input change.
  - Independent of clk and rst_n: s tracks a/b even while rst_n = 0.
- s_zero = NOR of all s bits; s_ones = AND of all s bits.
  - Both are combinational and unaffected by reset.
- Registered path, on rising clk edge with rst_n = 1:
  - If in_valid = 1: s_q <= a & b and s_q_valid <= 1.
  - If in_valid = 0: s_q holds its value and s_q_valid <= 0.
- Latency from in_valid to s_q_valid is 1 cycle. No backpressure; a new capture happens every cycle in_valid is high.
- Reset:
  - rst_n low forces s_q = 8'h00 and s_q_valid = 0 immediately, with no clock needed.
  - Outputs hold those values while rst_n stays low.
  - Reset asserted mid-stream discards any pending capture.
  - First capture happens on the first rising edge after rst_n deasserts with in_valid = 1.
- X/Z inputs propagate per standard gate semantics; no sanitising.
- Boundary cases:
  - a = 0 or b = 0 gives s = 0, s_zero = 1.
  - a = b = FF gives s = FF, s_ones = 1.

Decomposition:
- Shared package logic_ops_pkg holds:
  - localparam BYTE_W = 8
  - typedef logic [BYTE_W-1:0] byte_t
  - constants BYTE_ZERO = 8'h00 and BYTE_ONES = 8'hFF
- One sub-module, and_1_bit_cell: single gate-primitive AND with inputs a, b and output y.
  - Instantiated 8 times via a generate loop.
  - The flag reduction trees and the output register stay in the top level.

Test Plan:
- A = 8'hFF, B = 8'h00, wait 10 time units -> s = 8'h00, s_zero = 1, s_ones = 0.
- A = 8'hFF, B = 8'hA9 (1010 1001), wait 10 -> s = 8'hA9, s_zero = 0, s_ones = 0.
- A = 8'hFF, B = 8'hFF, wait 10 -> s = 8'hFF, s_ones = 1.
- Walking-one check:
  - For each i, set A = 8'h01 << i and B = 8'hFF -> s equals A.
  - Then set B = ~A -> s = 8'h00.
- Registered path:
  - Setup: rst_n = 0 -> s_q = 00, s_q_valid = 0. Release reset, drive A = 8'h3C, B = 8'h0F, in_valid = 1.
  - After 1 edge: s_q = 8'h0C, s_q_valid = 1.
  - Drop in_valid: next edge s_q_valid = 0 while s_q holds 8'h0C.
- Asynchronous reset:
  - Drive rst_n low between clock edges while s_q = 8'h0C -> s_q = 00 and s_q_valid = 0 before the next edge.
  - The combinational s still shows a & b during reset.
